// File: rtl/rca_sum_accumulator.sv
// rca_sum_accumulator
// Downstream stage of the 3-bit ripple-carry adder. Each accepted beat
// contributes {cout, sum} (0..15) to a frame total. When the last beat of a
// frame is accepted, the total, the saturating beat count and a sticky
// overflow flag are presented through a valid/ready handshake.
module rca_sum_accumulator #(
  parameter int ACC_W   = 8,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_sum,
  input  logic               in_cout,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_acc,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_ovf
);

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_W-1:0]     operand;
  logic [ACC_W:0]       sum_ext;

  // Operand is the adder's 4-bit result zero-extended; one extra bit of the
  // add captures the carry out of the accumulator width.
  assign operand = {{(ACC_W-4){1'b0}}, in_cout, in_sum};
  assign sum_ext = {1'b0, acc_q} + {1'b0, operand};

  // Handshake outputs depend only on the FSM state; result outputs are the
  // live registers, meaningful to downstream only while out_valid is high.
  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_OUT);
  assign out_acc   = acc_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

  // Next-state logic: accumulate on accepted beats, clear on release.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_ACC: begin
        if (in_valid) begin
          acc_d   = sum_ext[ACC_W-1:0];
          ovf_d   = ovf_q | sum_ext[ACC_W];
          count_d = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_W'(1);
          if (in_last) begin
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = S_ACC;
        end
      end
      default: begin
        state_d = S_ACC;
      end
    endcase
  end

  // State and result registers with synchronous reset discarding any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Testbench for rca_sum_accumulator: directed vector table, an overflow and
// saturation frame, and randomized traffic against a frame-level model.
module tb_rca_sum_accumulator;

  localparam int ACC_W   = 8;
  localparam int COUNT_W = 4;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_sum;
  logic               in_cout;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_acc;
  logic [COUNT_W-1:0] out_count;
  logic               out_ovf;

  int testsRun;
  int testsFailed;

  // Frame-level model: plain running total and beat count of the open frame.
  longint modelTotal;
  int     modelBeats;
  bit     modelHolding;

  typedef struct {
    bit       rst;
    bit       valid;
    bit [3:0] op;
    bit       last;
    bit       ready;
    bit       expReady;
    bit       expValid;
    int       expAcc;
    int       expCount;
    bit       expOvf;
  } vec_t;

  vec_t vecs[$];

  rca_sum_accumulator #(.ACC_W(ACC_W), .COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance past the edge, update the model.
  task automatic applyStimulus(input bit r, input bit v, input bit [3:0] op,
                               input bit l, input bit rdy);
    rst       = r;
    in_valid  = v;
    in_sum    = op[2:0];
    in_cout   = op[3];
    in_last   = l;
    out_ready = rdy;
    @(posedge clk);
    if (r) begin
      modelTotal   = 0;
      modelBeats   = 0;
      modelHolding = 0;
    end else if (!modelHolding) begin
      if (v) begin
        modelTotal = modelTotal + longint'(op);
        modelBeats = modelBeats + 1;
        if (l) modelHolding = 1;
      end
    end else if (rdy) begin
      modelTotal   = 0;
      modelBeats   = 0;
      modelHolding = 0;
    end
    #1;
  endtask

  // Compare all observable outputs as one record.
  task automatic checkOutput(input string name, input bit eR, input bit eV,
                             input int eAcc, input int eCnt, input bit eOvf);
    logic [ACC_W+COUNT_W+2:0] act, exp;
    act = {in_ready, out_valid, out_acc, out_count, out_ovf};
    exp = {eR, eV, eAcc[ACC_W-1:0], eCnt[COUNT_W-1:0], eOvf};
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got rdy=%b vld=%b acc=%0d cnt=%0d ovf=%b, want rdy=%b vld=%b acc=%0d cnt=%0d ovf=%b",
               name, in_ready, out_valid, out_acc, out_count, out_ovf,
               eR, eV, eAcc, eCnt, eOvf);
    end
  endtask

  // Expected outputs derived from the frame-level model.
  task automatic checkModel(input string name);
    int  cnt;
    int  acc;
    cnt = (modelBeats > (2**COUNT_W - 1)) ? (2**COUNT_W - 1) : modelBeats;
    acc = int'(modelTotal % (64'd1 << ACC_W));
    checkOutput(name, !modelHolding, modelHolding, acc, cnt,
                modelTotal >= (64'd1 << ACC_W));
  endtask

  function automatic void addVec(bit r, bit v, bit [3:0] op, bit l, bit rdy,
                                 bit eR, bit eV, int eAcc, int eCnt, bit eOvf);
    vec_t t;
    t.rst = r; t.valid = v; t.op = op; t.last = l; t.ready = rdy;
    t.expReady = eR; t.expValid = eV; t.expAcc = eAcc;
    t.expCount = eCnt; t.expOvf = eOvf;
    vecs.push_back(t);
  endfunction

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    modelTotal   = 0;
    modelBeats   = 0;
    modelHolding = 0;

    // Basic frame 5, 7, 15(last), then release.
    addVec(0,1, 5,0,1, 1,0, 5,1,0);
    addVec(0,1, 7,0,1, 1,0,12,2,0);
    addVec(0,1,15,1,1, 0,1,27,3,0);
    addVec(0,0, 0,0,1, 1,0, 0,0,0);
    // Backpressure: 3,3(last) held five cycles while in_valid pulses.
    addVec(0,1, 3,0,0, 1,0, 3,1,0);
    addVec(0,1, 3,1,0, 0,1, 6,2,0);
    addVec(0,1, 9,1,0, 0,1, 6,2,0);
    addVec(0,0, 9,0,0, 0,1, 6,2,0);
    addVec(0,1, 9,0,0, 0,1, 6,2,0);
    addVec(0,0, 9,1,0, 0,1, 6,2,0);
    addVec(0,1, 9,1,0, 0,1, 6,2,0);
    addVec(0,1, 9,1,1, 1,0, 0,0,0);
    addVec(0,1, 1,1,1, 0,1, 1,1,0);
    addVec(0,0, 0,0,1, 1,0, 0,0,0);
    // Bubbles, then an immediate single-beat frame.
    addVec(0,1, 2,0,1, 1,0, 2,1,0);
    addVec(0,0, 5,1,1, 1,0, 2,1,0);
    addVec(0,0, 5,1,1, 1,0, 2,1,0);
    addVec(0,0, 5,1,1, 1,0, 2,1,0);
    addVec(0,1, 4,1,1, 0,1, 6,2,0);
    addVec(0,0, 0,0,1, 1,0, 0,0,0);
    addVec(0,1, 9,1,0, 0,1, 9,1,0);
    addVec(0,0, 0,0,1, 1,0, 0,0,0);
    // Reset mid-frame discards the partial total.
    addVec(0,1,10,0,1, 1,0,10,1,0);
    addVec(0,1,10,0,1, 1,0,20,2,0);
    addVec(1,1,10,0,1, 1,0, 0,0,0);
    addVec(0,1, 3,1,1, 0,1, 3,1,0);
    addVec(0,0, 0,0,1, 1,0, 0,0,0);
    // Reset while holding a result.
    addVec(0,1,15,1,0, 0,1,15,1,0);
    addVec(1,0, 0,0,0, 1,0, 0,0,0);

    // Reset for two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    end
    checkOutput("reset", 1, 0, 0, 0, 0);

    // Directed vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].last,
                    vecs[i].ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expValid,
                  vecs[i].expAcc, vecs[i].expCount, vecs[i].expOvf);
    end

    // Overflow and count saturation: 18 beats of 15.
    for (int i = 1; i <= 18; i++) begin
      applyStimulus(0, 1, 4'd15, (i == 18), 1);
      if (i == 17) checkOutput("ovf_beat17", 1, 0, 255, 15, 0);
      else if (i == 18) checkOutput("ovf_beat18", 0, 1, 14, 15, 1);
      else checkModel($sformatf("ovf_beat%0d", i));
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("ovf_release", 1, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 9) < 7),
                    4'($urandom),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 9) < 6));
      checkModel($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
